// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
//   Multi-cycle signed/unsigned integer divider for the KGP-RISC ALU.
//   One quotient bit is resolved per clock using the restoring algorithm on
//   operand magnitudes; signs are re-applied in a final FIX cycle.
//   Quotient truncates toward zero, remainder takes the dividend's sign.
//
//   Optional build macro:
//     DIV_EARLY_TERM_EN - when defined, a divide whose divisor magnitude
//                         exceeds the dividend magnitude skips the iteration
//                         phase (Q=0, R=|a|) and completes in two cycles.
// ----------------------------------------------------------------------------
module seq_restoring_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

   // Two's-complement negate when n is set; used for operand magnitudes and
   // for re-applying the result signs.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             n);
      logic [WIDTH-1:0] r;
      r = n ? ((~v) + W_ONE) : v;
      return r;
   endfunction

   state_t           state_q, state_d;

   // iteration registers: partial remainder, shifting dividend/quotient,
   // divisor magnitude, sign flags and iteration count
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // architectural result registers
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   // operand conditioning for the IDLE capture
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             b_zero;
   logic             early_skip;

   // restoring step: shift {R,Q} left and trial-subtract at WIDTH+1 bits.
   // R < |b| always holds, so the shifted remainder never loses a bit and
   // bit WIDTH of the difference is a reliable borrow indicator.
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             trial_ok;

   assign a_neg  = signed_op & a[WIDTH-1];
   assign b_neg  = signed_op & b[WIDTH-1];
   assign a_mag  = cond_neg(a, a_neg);
   assign b_mag  = cond_neg(b, b_neg);
   assign b_zero = (b == '0);

`ifdef DIV_EARLY_TERM_EN
   // divisor larger than dividend: quotient is zero, remainder is |a|
   assign early_skip = (b_mag > a_mag);
`else
   assign early_skip = 1'b0;
`endif

   assign r_shift  = {rem_q, quo_q[WIDTH-1]};
   assign trial    = r_shift - {1'b0, dvs_q};
   assign trial_ok = ~trial[WIDTH];

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (b_zero) begin
                  state_d = S_DONE;
               end else if (early_skip) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (cnt_q == LAST_CNT) begin
               state_d = S_FIX;
            end
         end
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // status outputs decoded from the current state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            done = 1'b0;
         end
         S_RUN, S_FIX: begin
            busy = 1'b1;
            done = 1'b0;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // datapath next-state: operand capture, one restoring step per RUN cycle,
   // sign fix-up into the result registers
   always_comb begin
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvs_d   = b_mag;
               q_neg_d = a_neg ^ b_neg;
               r_neg_d = a_neg;
               rem_d   = '0;
               quo_d   = a_mag;
               cnt_d   = '0;
               dbz_d   = 1'b0;
               if (b_zero) begin
                  // results are final immediately; the raw dividend is
                  // returned so software can inspect it
                  quotient_d  = '1;
                  remainder_d = a;
                  dbz_d       = 1'b1;
               end else if (early_skip) begin
                  quo_d = '0;
                  rem_d = a_mag;
               end
            end
         end
         S_RUN: begin
            rem_d = trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], trial_ok};
            cnt_d = cnt_q + CNT_ONE;
         end
         S_FIX: begin
            // MIN / -1 lands here with Q = 2^(WIDTH-1) and q_neg = 0, which
            // reads back as MIN without any special casing
            quotient_d  = cond_neg(quo_q, q_neg_q);
            remainder_d = cond_neg(rem_q, r_neg_q);
         end
         default: begin
         end
      endcase
   end

   // datapath and result registers; reset clears everything so an aborted
   // operation leaves no stale results visible
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Directed bench for seq_restoring_divider (WIDTH=32). Expected results
//   come from a behavioural division model and travel through a scoreboard
//   queue from issue to completion. Honours DIV_EARLY_TERM_EN for latency.
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;

   localparam int W = 32;

`ifdef DIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         signed_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // behavioural reference: C-style truncating division on 64-bit values
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t         e;
      longint       sx, sy, qq, rr;
      logic [W-1:0] mx, my;
      e.dz = 1'b0;
      if (y == '0) begin
         e.q   = '1;
         e.r   = x;
         e.dz  = 1'b1;
         e.lat = 1;
         return e;
      end
      if (s) begin
         sx  = longint'($signed(x));
         sy  = longint'($signed(y));
         qq  = sx / sy;
         rr  = sx % sy;
         e.q = qq[W-1:0];
         e.r = rr[W-1:0];
      end else begin
         e.q = x / y;
         e.r = x % y;
      end
      mx = (s && x[W-1]) ? (~x + 32'd1) : x;
      my = (s && y[W-1]) ? (~y + 32'd1) : y;
      e.lat = (EARLY && (my > mx)) ? 2 : W + 2;
      return e;
   endfunction

   // issue one operation; optionally re-pulse start with other operands in
   // cycle glitch_cyc, which must be ignored
   task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input int glitch_cyc);
      exp_t e;
      int   cyc;
      bit   seen;
      int   busy_bad;
      @(negedge clk);
      a         = x;
      b         = y;
      signed_op = s;
      start     = 1'b1;
      sb.push_back(model(x, y, s));
      @(negedge clk);
      start    = 1'b0;
      a        = ~x;
      b        = y + 32'd1;
      cyc      = 1;
      seen     = 1'b0;
      busy_bad = 0;
      while (!seen && cyc <= 200) begin
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (cyc == glitch_cyc) begin
               start     = 1'b1;
               a         = 32'd9;
               b         = 32'd3;
               signed_op = ~s;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      check({tag, "/done_seen"}, 32'(seen), 32'd1);
      check({tag, "/latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "/busy_during"}, 32'(busy_bad), 32'd0);
      check({tag, "/quotient"}, quotient, e.q);
      check({tag, "/remainder"}, remainder, e.r);
      check({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
      @(negedge clk);
      check({tag, "/busy_after"}, 32'(busy), 32'd0);
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/q_held"}, quotient, e.q);
      check({tag, "/r_held"}, remainder, e.r);
   endtask

   initial begin
      int done_cnt;
      logic [W-1:0] rx, ry;
      logic         rs;
      rst       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/quotient", quotient, 32'd0);
      check("reset/remainder", remainder, 32'd0);
      check("reset/dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;

      run_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
      run_op("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);
      run_op("s100_-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0);
      run_op("div0", 32'h1234_5678, 32'd0, 1'b0, 0);
      run_op("dz_clear", 32'd100, 32'd7, 1'b1, 0);
      run_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("uffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op("s_div0", 32'h8000_0001, 32'd0, 1'b1, 0);
      run_op("glitch", 32'd1000, 32'd33, 1'b0, 5);
      run_op("u3_10", 32'd3, 32'd10, 1'b0, 0);
      run_op("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 0);
      run_op("u_big", 32'hFFFF_FFFE, 32'h8000_0000, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         rx = $urandom;
         ry = $urandom_range(1, 32'h0001_FFFF);
         rs = 1'(i % 2);
         if (i == 3) ry = -ry;
         run_op($sformatf("rand%0d", i), rx, ry, rs, 0);
      end

      // abort an operation with reset in cycle 10
      @(negedge clk);
      a         = 32'd5000;
      b         = 32'd3;
      signed_op = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/done", 32'(done), 32'd0);
      check("abort/quotient", quotient, 32'd0);
      check("abort/remainder", remainder, 32'd0);
      check("abort/dbz", 32'(div_by_zero), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
         @(negedge clk);
      end
      check("abort/no_done", 32'(done_cnt), 32'd0);
      check("abort/sb_empty", 32'(sb.size()), 32'd0);

      run_op("post_rst", 32'd77, 32'hFFFF_FFFB, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // hard time limit in case the design wedges in a way the bounded waits miss
   initial begin
      #2_000_000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
